// File: rtl/cga_mac_lasel_seq_if.sv
// Requester/memory handshake bundle between the CGA MAC requesters and the LASEL sequencer.
// The master side drives the requests and MEM_RDY; the slave side is the sequencer.
interface cga_mac_lasel_seq_if;
    logic CPU_REQ;
    logic CPU_DBL;
    logic DMA_REQ;
    logic DMA_DBL;
    logic MEM_RDY;
    logic CSMREQ;
    logic DOUBLE;
    logic SEL_DMA;
    logic BUSY;
    logic CPU_ACK;
    logic DMA_ACK;
    logic TMO_ERR;

    modport master (
        output CPU_REQ, CPU_DBL, DMA_REQ, DMA_DBL, MEM_RDY,
        input  CSMREQ, DOUBLE, SEL_DMA, BUSY, CPU_ACK, DMA_ACK, TMO_ERR
    );

    modport slave (
        input  CPU_REQ, CPU_DBL, DMA_REQ, DMA_DBL, MEM_RDY,
        output CSMREQ, DOUBLE, SEL_DMA, BUSY, CPU_ACK, DMA_ACK, TMO_ERR
    );
endinterface

// File: rtl/cga_mac_lasel_seq.sv
// Memory-cycle sequencer and round-robin CPU/DMA arbiter feeding CSMREQ/DOUBLE into LASEL.
// Every output is a register, so an asynchronous reset clears them without a clock edge.
module cga_mac_lasel_seq #(
    parameter int TMO_CYCLES = 255,
    parameter int CNT_W      = 8
) (
    input logic                 MCLK,
    input logic                 RESETN,
    cga_mac_lasel_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value seen on the last allowed wait cycle of a beat.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbl_q;
    logic             last_dma_q;
    logic             csmreq_q;
    logic             double_q;
    logic             sel_dma_q;
    logic             busy_q;
    logic             cpu_ack_q;
    logic             dma_ack_q;
    logic             tmo_err_q;

    logic             grant_dma_d;
    logic             timeout_d;

    always_comb begin
        grant_dma_d = bus.DMA_REQ && (!bus.CPU_REQ || !last_dma_q);
        timeout_d   = (cnt_q == TMO_LAST);
    end

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dbl_q      <= 1'b0;
            last_dma_q <= 1'b1;
            csmreq_q   <= 1'b0;
            double_q   <= 1'b0;
            sel_dma_q  <= 1'b0;
            busy_q     <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.CPU_REQ || bus.DMA_REQ) begin
                        state_q    <= BEAT0;
                        sel_dma_q  <= grant_dma_d;
                        dbl_q      <= grant_dma_d ? bus.DMA_DBL : bus.CPU_DBL;
                        last_dma_q <= grant_dma_d;
                        csmreq_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus.MEM_RDY && (state_q == BEAT0) && dbl_q) begin
                        state_q  <= BEAT1;
                        double_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (bus.MEM_RDY || timeout_d) begin
                        // MEM_RDY on the final allowed cycle still counts as a success.
                        state_q   <= DONE;
                        csmreq_q  <= 1'b0;
                        double_q  <= 1'b0;
                        cpu_ack_q <= !sel_dma_q;
                        dma_ack_q <= sel_dma_q;
                        tmo_err_q <= !bus.MEM_RDY;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    tmo_err_q <= 1'b0;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.CSMREQ  = csmreq_q;
    assign bus.DOUBLE  = double_q;
    assign bus.SEL_DMA = sel_dma_q;
    assign bus.BUSY    = busy_q;
    assign bus.CPU_ACK = cpu_ack_q;
    assign bus.DMA_ACK = dma_ack_q;
    assign bus.TMO_ERR = tmo_err_q;

endmodule

// File: tb/tb_cga_mac_lasel_seq.sv
// Bench for cga_mac_lasel_seq: requesters and memory are modelled per access as beat plans,
// and each expected cycle of an access is derived from the plan and the round-robin rule.
module tb_cga_mac_lasel_seq;

    localparam int TMO = 4;

    logic MCLK = 1'b0;
    logic RESETN;

    always #5 MCLK = ~MCLK;

    cga_mac_lasel_seq_if bus ();

    cga_mac_lasel_seq #(
        .TMO_CYCLES (TMO),
        .CNT_W      (8)
    ) dut (
        .MCLK   (MCLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side view: pending request and its width, plus who won last.
    bit cpu_pend, dma_pend, cpu_dblv, dma_dblv, last_dma;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        bus.CPU_REQ = cpu_pend;
        bus.CPU_DBL = cpu_dblv;
        bus.DMA_REQ = dma_pend;
        bus.DMA_DBL = dma_dblv;
    endtask

    always @(negedge MCLK) begin
        if (RESETN && (bus.CPU_ACK || bus.DMA_ACK)) begin
            check("ack_exclusive", bus.CPU_ACK & bus.DMA_ACK, 1'b0);
            check("csmreq_off_at_ack", bus.CSMREQ, 1'b0);
        end
    end

    // Called at a negedge while the sequencer is idle; returns at the following idle negedge.
    // d0/d1: beat cycle on which MEM_RDY pulses; a value above TMO means no MEM_RDY at all.
    task automatic run_txn(input bit raise_cpu, input bit raise_dma, input bit cdbl,
                           input bit ddbl, input int d0, input int d1, input bit drop_noise);
        bit win_dma, dbl, err;
        int dl[2];
        int len[2];
        int nb;
        check("idle_busy", bus.BUSY, 1'b0);
        check("idle_csmreq", bus.CSMREQ, 1'b0);
        if (raise_cpu && !cpu_pend) begin cpu_pend = 1'b1; cpu_dblv = cdbl; end
        if (raise_dma && !dma_pend) begin dma_pend = 1'b1; dma_dblv = ddbl; end
        drive_reqs();
        bus.MEM_RDY = 1'($urandom_range(0, 1));
        if (!cpu_pend && !dma_pend) begin
            @(negedge MCLK);
            check("noreq_stays_idle", bus.BUSY, 1'b0);
            return;
        end
        win_dma = dma_pend && (!cpu_pend || !last_dma);
        dbl     = win_dma ? dma_dblv : cpu_dblv;
        dl[0] = d0;
        dl[1] = d1;
        nb  = dbl ? 2 : 1;
        err = 1'b0;
        for (int b = 0; b < 2; b++) begin
            len[b] = (dl[b] <= TMO) ? dl[b] : TMO;
            if (b < nb && dl[b] > TMO) begin
                err = 1'b1;
                nb  = b + 1;
            end
        end
        @(negedge MCLK);
        for (int b = 0; b < nb; b++) begin
            for (int k = 1; k <= len[b]; k++) begin
                check("beat_csmreq", bus.CSMREQ, 1'b1);
                check("beat_double", bus.DOUBLE, (b == 1));
                check("beat_sel_dma", bus.SEL_DMA, win_dma);
                check("beat_busy", bus.BUSY, 1'b1);
                check("beat_no_ack", bus.CPU_ACK | bus.DMA_ACK, 1'b0);
                bus.MEM_RDY = (k == dl[b]);
                if (drop_noise && b == 0 && k == 1) begin
                    if (win_dma) dma_pend = 1'b0; else cpu_pend = 1'b0;
                    drive_reqs();
                end
                @(negedge MCLK);
            end
        end
        check("done_csmreq", bus.CSMREQ, 1'b0);
        check("done_double", bus.DOUBLE, 1'b0);
        check("done_cpu_ack", bus.CPU_ACK, !win_dma);
        check("done_dma_ack", bus.DMA_ACK, win_dma);
        check("done_tmo_err", bus.TMO_ERR, err);
        check("done_busy", bus.BUSY, 1'b1);
        check("done_sel_dma", bus.SEL_DMA, win_dma);
        bus.MEM_RDY = 1'($urandom_range(0, 1));
        @(negedge MCLK);
        check("post_no_ack", bus.CPU_ACK | bus.DMA_ACK, 1'b0);
        check("post_tmo_err", bus.TMO_ERR, 1'b0);
        check("post_busy", bus.BUSY, 1'b0);
        check("post_sel_hold", bus.SEL_DMA, win_dma);
        if (win_dma) dma_pend = 1'b0; else cpu_pend = 1'b0;
        last_dma = win_dma;
        drive_reqs();
        bus.MEM_RDY = 1'b0;
    endtask

    initial begin
        RESETN   = 1'b0;
        cpu_pend = 1'b0; dma_pend = 1'b0;
        cpu_dblv = 1'b0; dma_dblv = 1'b0;
        last_dma = 1'b1;
        drive_reqs();
        bus.MEM_RDY = 1'b0;
        repeat (3) @(negedge MCLK);
        check("rst_csmreq", bus.CSMREQ, 1'b0);
        check("rst_double", bus.DOUBLE, 1'b0);
        check("rst_sel_dma", bus.SEL_DMA, 1'b0);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_cpu_ack", bus.CPU_ACK, 1'b0);
        check("rst_dma_ack", bus.DMA_ACK, 1'b0);
        check("rst_tmo_err", bus.TMO_ERR, 1'b0);
        RESETN = 1'b1;

        // Single CPU, double DMA, then a held tie to exercise round-robin.
        run_txn(1, 0, 0, 0, 3, 1, 0);
        run_txn(0, 1, 0, 1, 2, 1, 0);
        run_txn(1, 1, 0, 0, 1, 1, 0);
        run_txn(1, 0, 0, 0, 2, 1, 0);
        run_txn(0, 1, 1, 0, 1, 2, 0);
        run_txn(1, 0, 0, 0, 1, 1, 0);
        // Timeout, boundary success, second-beat timeout, REQ drop during BEAT0.
        run_txn(1, 0, 0, 0, TMO + 2, 1, 0);
        run_txn(1, 0, 0, 0, TMO, 1, 0);
        run_txn(0, 1, 0, 1, 1, TMO + 1, 0);
        run_txn(0, 1, 0, 0, 3, 1, 1);
        for (int i = 0; i < 3 && (cpu_pend || dma_pend); i++)
            run_txn(0, 0, 0, 0, 1, 1, 0);

        // Asynchronous reset in the middle of BEAT1.
        dma_pend = 1'b1; dma_dblv = 1'b1;
        drive_reqs();
        bus.MEM_RDY = 1'b0;
        @(negedge MCLK);
        bus.MEM_RDY = 1'b1;
        @(negedge MCLK);
        check("pre_rst_double", bus.DOUBLE, 1'b1);
        bus.MEM_RDY = 1'b0;
        cpu_pend = 1'b1; cpu_dblv = 1'b0;
        drive_reqs();
        #2 RESETN = 1'b0;
        #1;
        check("async_rst_csmreq", bus.CSMREQ, 1'b0);
        check("async_rst_double", bus.DOUBLE, 1'b0);
        check("async_rst_busy", bus.BUSY, 1'b0);
        check("async_rst_ack", bus.CPU_ACK | bus.DMA_ACK, 1'b0);
        repeat (2) begin
            @(negedge MCLK);
            check("in_rst_no_ack", bus.CPU_ACK | bus.DMA_ACK, 1'b0);
            check("in_rst_busy", bus.BUSY, 1'b0);
        end
        RESETN   = 1'b1;
        last_dma = 1'b1;
        run_txn(0, 0, 0, 0, 2, 1, 0);

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, TMO + 2)), int'($urandom_range(1, TMO + 2)),
                    1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
